// File: rtl/sb_msg_decoder.sv
// Sideband message decoder: fetches header (and payload) words from the
// receiver FIFO, checks parity and presents decoded fields until acked.
module sb_msg_decoder #(
  parameter int RETRY_CYCLES = 8
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [63:0] rx_data_i,
  input  logic        rx_valid_i,
  output logic        msg_req_o,
  output logic        msg_valid_o,
  input  logic        msg_ack_i,
  output logic [4:0]  opcode_o,
  output logic [2:0]  srcid_o,
  output logic [2:0]  dstid_o,
  output logic [7:0]  msgcode_o,
  output logic [7:0]  msgsubcode_o,
  output logic [15:0] msginfo_o,
  output logic [63:0] data_o,
  output logic        has_data_o,
  output logic        parity_err_o,
  output logic        unsup_op_o,
  output logic [7:0]  err_cnt_o
);

  localparam logic [4:0] OP_HDR  = 5'b10010;
  localparam logic [4:0] OP_DATA = 5'b11011;
  localparam logic [7:0] RETRY_MAX = 8'(RETRY_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    REQ_HDR,
    WAIT_HDR,
    REQ_DATA,
    WAIT_DATA,
    OUT
  } state_t;

  state_t      state;
  logic [7:0]  retry_cnt;
  logic [63:0] hdr_q;

  logic [63:0] fin_hdr;
  logic [63:0] fin_pay;
  logic        fin_has;
  logic        dp_exp;
  logic        fin_perr;
  logic        fin_unsup;
  logic        enter_out;

  // Final message view, valid in the cycle that moves the FSM into OUT.
  always_comb begin
    fin_hdr   = hdr_q;
    fin_pay   = '0;
    fin_has   = 1'b0;
    enter_out = 1'b0;
    if (state == WAIT_HDR) begin
      fin_hdr   = rx_data_i;
      enter_out = enable_i && rx_valid_i
                  && (rx_data_i[4:0] != OP_DATA);
    end
    if (state == WAIT_DATA) begin
      fin_pay   = rx_data_i;
      fin_has   = 1'b1;
      enter_out = enable_i && rx_valid_i;
    end
    dp_exp    = (fin_hdr[4:0] == OP_DATA) ? ^fin_pay : 1'b0;
    fin_perr  = (fin_hdr[62] != ^fin_hdr[61:0])
                || (fin_hdr[63] != dp_exp);
    fin_unsup = (fin_hdr[4:0] != OP_HDR)
                && (fin_hdr[4:0] != OP_DATA);
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state        <= IDLE;
      retry_cnt    <= '0;
      hdr_q        <= '0;
      msg_req_o    <= 1'b0;
      msg_valid_o  <= 1'b0;
      opcode_o     <= '0;
      srcid_o      <= '0;
      dstid_o      <= '0;
      msgcode_o    <= '0;
      msgsubcode_o <= '0;
      msginfo_o    <= '0;
      data_o       <= '0;
      has_data_o   <= 1'b0;
      parity_err_o <= 1'b0;
      unsup_op_o   <= 1'b0;
      err_cnt_o    <= '0;
    end else begin
      msg_req_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable_i && !msg_valid_o) begin
            state     <= REQ_HDR;
            msg_req_o <= 1'b1;
          end
        end
        REQ_HDR, REQ_DATA: begin
          retry_cnt <= '0;
          if (!enable_i)
            state <= IDLE;
          else if (state == REQ_HDR)
            state <= WAIT_HDR;
          else
            state <= WAIT_DATA;
        end
        WAIT_HDR, WAIT_DATA: begin
          if (!enable_i) begin
            state <= IDLE;
          end else if (rx_valid_i) begin
            if (state == WAIT_HDR)
              hdr_q <= rx_data_i;
            if (enter_out) begin
              state <= OUT;
            end else begin
              state     <= REQ_DATA;
              msg_req_o <= 1'b1;
            end
          end else if (retry_cnt == RETRY_MAX) begin
            state     <= (state == WAIT_HDR) ? REQ_HDR : REQ_DATA;
            msg_req_o <= 1'b1;
          end else begin
            retry_cnt <= retry_cnt + 8'd1;
          end
        end
        OUT: begin
          if (msg_ack_i) begin
            msg_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (enter_out) begin
        msg_valid_o  <= 1'b1;
        opcode_o     <= fin_hdr[4:0];
        msgcode_o    <= fin_hdr[21:14];
        srcid_o      <= fin_hdr[31:29];
        msgsubcode_o <= fin_hdr[39:32];
        msginfo_o    <= fin_hdr[55:40];
        dstid_o      <= fin_hdr[58:56];
        data_o       <= fin_pay;
        has_data_o   <= fin_has;
        parity_err_o <= fin_perr;
        unsup_op_o   <= fin_unsup;
        if (fin_perr && err_cnt_o != 8'hFF)
          err_cnt_o <= err_cnt_o + 8'd1;
      end
    end
  end

endmodule
